vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter HACTIVE, default 640, horizontal active pixels.
REQ-002 SHALL have parameter HFP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter HSYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter HBP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter VACTIVE, default 480, vertical active lines.
REQ-006 SHALL have parameter VFP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter VSYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter VBP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter HPOL, default 0, hsync asserted level.
REQ-010 SHALL have parameter VPOL, default 0, vsync asserted level.
REQ-011 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel; legal range 1..16.
REQ-012 SHALL have parameter PIPE, default 1, output register stages; legal range 1..3.
REQ-013 SHALL have parameter XW, default 10, posx width; YW, default 9, posy width.
REQ-014 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-015 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-016 SHALL have port en  input  1  run enable; low freezes all timing state.
REQ-017 SHALL have ports hsync, vsync  output  1 each  sync pulses at HPOL/VPOL level.
REQ-018 SHALL have port blank_n  output  1  high only inside the active region.
REQ-019 SHALL have ports posx  output  XW and posy  output  YW  active pixel coordinates.
REQ-020 SHALL have port pix_valid  output  1  one-clk strobe marking each new pixel.
REQ-021 SHALL have ports line_start, frame_start  output  1 each  one-clk strobes.

Function
REQ-022 SHALL define HTOT=HACTIVE+HFP+HSYNC+HBP and VTOT=VACTIVE+VFP+VSYNC+VBP; the counters are sized to hold HTOT-1 and VTOT-1.
REQ-023 SHALL run a divider counter 0..CLK_DIV-1 that advances when en=1; tick=1 when en=1 and divider=CLK_DIV-1. With CLK_DIV=1, tick=en.
REQ-024 SHALL advance hcnt on tick; at HTOT-1 it wraps to 0 and vcnt advances. vcnt wraps VTOT-1 -> 0 when hcnt wraps.
REQ-025 SHALL order each line as active [0,HACTIVE-1], front porch, sync [HACTIVE+HFP, HACTIVE+HFP+HSYNC-1], back porch. Vertical order is the same, using vcnt.
REQ-026 SHALL decode hsync=HPOL inside the h-sync window, else ~HPOL. vsync uses VPOL and the v-sync window and changes only at line boundaries.
REQ-027 SHALL decode blank_n=(hcnt<HACTIVE)&&(vcnt<VACTIVE).
REQ-028 SHALL decode posx=hcnt when hcnt<HACTIVE, else 0, and posy=vcnt when vcnt<VACTIVE, else 0, each truncated to XW/YW.
REQ-029 SHALL decode pix_valid=tick. line_start=tick&&hcnt==0. frame_start=tick&&hcnt==0&&vcnt==0.
REQ-030 SHALL delay all decoded outputs by exactly PIPE registered stages, so every output stays mutually aligned.
REQ-031 SHALL hold the divider, counters and pipeline contents while en=0; the strobes are 0 while frozen.
REQ-032 SHALL make the strobes exactly one clk wide for any CLK_DIV. Level outputs hold for CLK_DIV clks per pixel.

Reset
REQ-033 SHALL, on a clk edge with rst=0, clear the divider, hcnt and vcnt to 0, overriding en.
REQ-034 SHALL, on the same edge, load every pipeline stage with: hsync=~HPOL, vsync=~VPOL, blank_n=0, posx=0, posy=0, pix_valid=0, line_start=0, frame_start=0.
REQ-035 SHALL abandon any frame in progress on reset mid-frame. The first strobes after release describe position (0,0) and appear PIPE clks after the first tick.

Verification
REQ-036 Defaults, en=1, rst released -> frame_start every 2*800*525=840000 clks; line_start every 1600 clks.
REQ-037 Defaults -> hsync low for 192 clks starting 1312 clks after line_start; vsync low for 2 lines starting at line 490.
REQ-038 Defaults -> blank_n high for 1280 clks per line on lines 0..479; posx runs 0..639 then reads 0; posy=479 on the last active line.
REQ-039 CLK_DIV=1, PIPE=3 -> frame_start rises on the 3rd clk after rst release; all outputs stay aligned.
REQ-040 en=0 for 37 clks mid-line -> all outputs hold, strobes are 0, and the timing resumes with no lost or extra pixel.
REQ-041 rst=0 asserted at hcnt=700, vcnt=300 -> outputs take reset values next edge; after release the next frame_start occurs with posx=0, posy=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parameterised VGA raster timing generator. A clock divider produces one
//   pixel tick every CLK_DIV clocks. Horizontal and vertical counters walk the
//   raster in the order active, front porch, sync, back porch. The decoded
//   sync, blank and position outputs, plus the per-pixel strobes, leave through
//   a PIPE-deep register pipeline so that all outputs stay mutually aligned.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-low reset
//   en           in   run enable; low freezes divider, counters and pipeline
//   hsync        out  horizontal sync, HPOL level inside the sync window
//   vsync        out  vertical sync, VPOL level inside the sync window
//   blank_n      out  high only inside the active region
//   posx [XW]    out  active pixel column, 0 outside the active region
//   posy [YW]    out  active line number, 0 outside the active region
//   pix_valid    out  one-clk strobe for each new pixel
//   line_start   out  one-clk strobe on the first pixel of each line
//   frame_start  out  one-clk strobe on the first pixel of each frame
module vga_timing_gen #(
  parameter int HACTIVE = 640,
  parameter int HFP     = 16,
  parameter int HSYNC   = 96,
  parameter int HBP     = 48,
  parameter int VACTIVE = 480,
  parameter int VFP     = 10,
  parameter int VSYNC   = 2,
  parameter int VBP     = 33,
  parameter int HPOL    = 0,
  parameter int VPOL    = 0,
  parameter int CLK_DIV = 2,
  parameter int PIPE    = 1,
  parameter int XW      = 10,
  parameter int YW      = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic [XW-1:0] posx,
  output logic [YW-1:0] posy,
  output logic          pix_valid,
  output logic          line_start,
  output logic          frame_start
);

  localparam int HTOT = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOT = VACTIVE + VFP + VSYNC + VBP;
  localparam int HCW  = (HTOT > 1) ? $clog2(HTOT) : 1;
  localparam int VCW  = (VTOT > 1) ? $clog2(VTOT) : 1;
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0]  DIV_LAST     = DW'(CLK_DIV - 1);
  localparam logic [HCW-1:0] H_LAST       = HCW'(HTOT - 1);
  localparam logic [HCW-1:0] H_ACT_LAST   = HCW'(HACTIVE - 1);
  localparam logic [HCW-1:0] H_SYNC_FIRST = HCW'(HACTIVE + HFP);
  localparam logic [HCW-1:0] H_SYNC_LAST  = HCW'(HACTIVE + HFP + HSYNC - 1);
  localparam logic [VCW-1:0] V_LAST       = VCW'(VTOT - 1);
  localparam logic [VCW-1:0] V_ACT_LAST   = VCW'(VACTIVE - 1);
  localparam logic [VCW-1:0] V_SYNC_FIRST = VCW'(VACTIVE + VFP);
  localparam logic [VCW-1:0] V_SYNC_LAST  = VCW'(VACTIVE + VFP + VSYNC - 1);
  localparam logic           HPOL_L       = 1'(HPOL);
  localparam logic           VPOL_L       = 1'(VPOL);

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          bn;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          pv;
    logic          ls;
    logic          fs;
  } pix_t;

  // Idle output word: syncs deasserted, blanked, origin, no strobes.
  function automatic pix_t idle_pix();
    pix_t p;
    p.hs = ~HPOL_L;
    p.vs = ~VPOL_L;
    p.bn = 1'b0;
    p.px = '0;
    p.py = '0;
    p.pv = 1'b0;
    p.ls = 1'b0;
    p.fs = 1'b0;
    return p;
  endfunction

  logic [DW-1:0]  r_div;
  logic [HCW-1:0] r_hcnt;
  logic [VCW-1:0] r_vcnt;
  logic           w_tick;
  logic           w_h_act;
  logic           w_v_act;
  logic           w_h_sync;
  logic           w_v_sync;
  pix_t           w_dec;
  pix_t           w_stage0;
  pix_t           r_pipe [PIPE];

  assign w_tick   = en && (r_div == DIV_LAST);
  assign w_h_act  = (r_hcnt <= H_ACT_LAST);
  assign w_v_act  = (r_vcnt <= V_ACT_LAST);
  assign w_h_sync = (r_hcnt >= H_SYNC_FIRST) && (r_hcnt <= H_SYNC_LAST);
  assign w_v_sync = (r_vcnt >= V_SYNC_FIRST) && (r_vcnt <= V_SYNC_LAST);

  // Pixel divider and raster counters; all frozen while en is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div  <= '0;
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (en) begin
      if (w_tick) begin
        r_div <= '0;
        if (r_hcnt == H_LAST) begin
          r_hcnt <= '0;
          if (r_vcnt == V_LAST) begin
            r_vcnt <= '0;
          end else begin
            r_vcnt <= r_vcnt + VCW'(1);
          end
        end else begin
          r_hcnt <= r_hcnt + HCW'(1);
        end
      end else begin
        r_div <= r_div + DW'(1);
      end
    end else begin
      r_div  <= r_div;
      r_hcnt <= r_hcnt;
      r_vcnt <= r_vcnt;
    end
  end

  // Decode the current raster position into an output word.
  always_comb begin
    w_dec = idle_pix();
    if (w_h_sync) begin
      w_dec.hs = HPOL_L;
    end else begin
      w_dec.hs = ~HPOL_L;
    end
    if (w_v_sync) begin
      w_dec.vs = VPOL_L;
    end else begin
      w_dec.vs = ~VPOL_L;
    end
    w_dec.bn = w_h_act && w_v_act;
    w_dec.px = w_h_act ? XW'(r_hcnt) : '0;
    w_dec.py = w_v_act ? YW'(r_vcnt) : '0;
    w_dec.pv = w_tick;
    w_dec.ls = w_tick && (r_hcnt == '0);
    w_dec.fs = w_tick && (r_hcnt == '0) && (r_vcnt == '0);
  end

  // First pipeline stage: strobes follow the tick every clock, while the
  // level fields are captured only on a tick so that each pixel's levels
  // start together with its pix_valid strobe and hold for CLK_DIV clocks.
  always_comb begin
    w_stage0    = r_pipe[0];
    w_stage0.pv = w_dec.pv;
    w_stage0.ls = w_dec.ls;
    w_stage0.fs = w_dec.fs;
    if (w_tick) begin
      w_stage0.hs = w_dec.hs;
      w_stage0.vs = w_dec.vs;
      w_stage0.bn = w_dec.bn;
      w_stage0.px = w_dec.px;
      w_stage0.py = w_dec.py;
    end else begin
      w_stage0.hs = r_pipe[0].hs;
      w_stage0.vs = r_pipe[0].vs;
      w_stage0.bn = r_pipe[0].bn;
      w_stage0.px = r_pipe[0].px;
      w_stage0.py = r_pipe[0].py;
    end
  end

  // Output pipeline; holds its contents while en is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PIPE; i++) begin
        r_pipe[i] <= idle_pix();
      end
    end else if (en) begin
      r_pipe[0] <= w_stage0;
      for (int i = 1; i < PIPE; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end else begin
      for (int i = 0; i < PIPE; i++) begin
        r_pipe[i] <= r_pipe[i];
      end
    end
  end

  assign hsync   = r_pipe[PIPE-1].hs;
  assign vsync   = r_pipe[PIPE-1].vs;
  assign blank_n = r_pipe[PIPE-1].bn;
  assign posx    = r_pipe[PIPE-1].px;
  assign posy    = r_pipe[PIPE-1].py;
  // A strobe parked in the last stage while frozen must not repeat every
  // clock, so strobes are masked by en; the held strobe is released on the
  // first enabled clock, so no pixel is lost or duplicated.
  assign pix_valid   = r_pipe[PIPE-1].pv && en;
  assign line_start  = r_pipe[PIPE-1].ls && en;
  assign frame_start = r_pipe[PIPE-1].fs && en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with three instances:
//   A: default 640x480 timing, CLK_DIV=2, PIPE=1
//   B: small 16x12 raster, CLK_DIV=2, PIPE=2, active-high syncs
//   C: small 16x12 raster, CLK_DIV=1, PIPE=3
// Output words are sampled on the falling edge as
//   {hsync, vsync, blank_n, posx, posy, pix_valid, line_start, frame_start}
// and compared with values computed from clock index t, where t=0 is the
// sample showing the first strobes after reset release.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A
  logic       rst_a, en_a, hs_a, vs_a, bn_a, pv_a, ls_a, fs_a;
  logic [9:0] px_a;
  logic [8:0] py_a;
  logic [24:0] obs_a;
  assign obs_a = {hs_a, vs_a, bn_a, px_a, py_a, pv_a, ls_a, fs_a};
  localparam logic [24:0] RST_A = {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 3'b000};
  int t_a = 0;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .hsync(hs_a), .vsync(vs_a),
    .blank_n(bn_a), .posx(px_a), .posy(py_a), .pix_valid(pv_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  // Instance B
  logic       rst_b, en_b, hs_b, vs_b, bn_b, pv_b, ls_b, fs_b;
  logic [3:0] px_b;
  logic [2:0] py_b;
  logic [12:0] obs_b;
  assign obs_b = {hs_b, vs_b, bn_b, px_b, py_b, pv_b, ls_b, fs_b};
  localparam logic [12:0] RST_B = {1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'b000};
  int t_b = 0;

  vga_timing_gen #(
    .HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(3),
    .VACTIVE(6), .VFP(2), .VSYNC(2), .VBP(2),
    .HPOL(1), .VPOL(1), .CLK_DIV(2), .PIPE(2), .XW(4), .YW(3)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .hsync(hs_b), .vsync(vs_b),
    .blank_n(bn_b), .posx(px_b), .posy(py_b), .pix_valid(pv_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  // Instance C
  logic       rst_c, en_c, hs_c, vs_c, bn_c, pv_c, ls_c, fs_c;
  logic [3:0] px_c;
  logic [2:0] py_c;
  logic [12:0] obs_c;
  assign obs_c = {hs_c, vs_c, bn_c, px_c, py_c, pv_c, ls_c, fs_c};
  localparam logic [12:0] RST_C = {1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 3'b000};

  vga_timing_gen #(
    .HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(3),
    .VACTIVE(6), .VFP(2), .VSYNC(2), .VBP(2),
    .HPOL(0), .VPOL(0), .CLK_DIV(1), .PIPE(3), .XW(4), .YW(3)
  ) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .hsync(hs_c), .vsync(vs_c),
    .blank_n(bn_c), .posx(px_c), .posy(py_c), .pix_valid(pv_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  // Expected word for A: 1600 clks per line, 2 clks per pixel.
  function automatic logic [24:0] exp_a(input int t);
    int line, p;
    logic hs, vs, bn;
    logic [9:0] px;
    logic [8:0] py;
    line = (t / 1600) % 525;
    p    = (t % 1600) / 2;
    hs   = (p >= 656 && p < 752) ? 1'b0 : 1'b1;
    vs   = (line >= 490 && line < 492) ? 1'b0 : 1'b1;
    bn   = (p < 640) && (line < 480);
    px   = (p < 640) ? 10'(p) : 10'd0;
    py   = (line < 480) ? 9'(line) : 9'd0;
    return {hs, vs, bn, px, py, (t % 2 == 0), (t % 1600 == 0), (t % 840000 == 0)};
  endfunction

  // Expected word for B: 32 clks per line, 12 lines, syncs active high.
  function automatic logic [12:0] exp_b(input int t);
    int line, p;
    logic [3:0] px;
    logic [2:0] py;
    line = (t / 32) % 12;
    p    = (t % 32) / 2;
    px   = (p < 8) ? 4'(p) : 4'd0;
    py   = (line < 6) ? 3'(line) : 3'd0;
    return {(p >= 10 && p < 13), (line >= 8 && line < 10), (p < 8 && line < 6),
            px, py, (t % 2 == 0), (t % 32 == 0), (t % 384 == 0)};
  endfunction

  // Expected word for C: 16 clks per line, one pixel per clk, active-low syncs.
  function automatic logic [12:0] exp_c(input int t);
    int line, p;
    logic [3:0] px;
    logic [2:0] py;
    line = (t / 16) % 12;
    p    = t % 16;
    px   = (p < 8) ? 4'(p) : 4'd0;
    py   = (line < 6) ? 3'(line) : 3'd0;
    return {!(p >= 10 && p < 13), !(line >= 8 && line < 10), (p < 8 && line < 6),
            px, py, 1'b1, (p == 0), (t % 192 == 0)};
  endfunction

  task automatic test_reset();
    rst_a = 1'b0;
    en_a  = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs_a !== RST_A) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs_a, RST_A);
    end
    en_a = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs_a !== RST_A) begin
      n_fail++;
      $display("FAIL reset_with_en_low: got %h expected %h", obs_a, RST_A);
    end
    en_a  = 1'b1;
    rst_a = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs_a !== RST_A) begin
      n_fail++;
      $display("FAIL release_before_tick: got %h expected %h", obs_a, RST_A);
    end
    @(negedge clk);
    t_a = 0;
    n_tests++;
    if (obs_a !== exp_a(0)) begin
      n_fail++;
      $display("FAIL first_pixel: got %h expected %h", obs_a, exp_a(0));
    end
  endtask

  task automatic test_line_timing();
    int shown = 0;
    for (int i = 1; i < 3200; i++) begin
      @(negedge clk);
      t_a = i;
      n_tests++;
      if (obs_a !== exp_a(t_a)) begin
        n_fail++;
        if (shown < 5) $display("FAIL line_timing t=%0d: got %h expected %h", t_a, obs_a, exp_a(t_a));
        shown++;
      end
    end
  endtask

  task automatic test_freeze();
    int shown = 0;
    logic [24:0] ev;
    logic [24:0] frozen;
    while (t_a < 3600) begin
      @(negedge clk);
      t_a++;
      n_tests++;
      if (obs_a !== exp_a(t_a)) begin
        n_fail++;
        if (shown < 5) $display("FAIL pre_freeze t=%0d: got %h expected %h", t_a, obs_a, exp_a(t_a));
        shown++;
      end
    end
    ev     = exp_a(t_a);
    frozen = {ev[24:3], 3'b000};
    en_a   = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_a !== frozen) begin
        n_fail++;
        if (shown < 5) $display("FAIL frozen clk=%0d: got %h expected %h", i, obs_a, frozen);
        shown++;
      end
    end
    en_a = 1'b1;
    while (t_a < 4810) begin
      @(negedge clk);
      t_a++;
      n_tests++;
      if (obs_a !== exp_a(t_a)) begin
        n_fail++;
        if (shown < 5) $display("FAIL post_freeze t=%0d: got %h expected %h", t_a, obs_a, exp_a(t_a));
        shown++;
      end
    end
  endtask

  task automatic test_midline_reset_a();
    int shown = 0;
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_a !== RST_A) begin
        n_fail++;
        $display("FAIL midline_reset clk=%0d: got %h expected %h", i, obs_a, RST_A);
      end
    end
    rst_a = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs_a !== RST_A) begin
      n_fail++;
      $display("FAIL midline_release: got %h expected %h", obs_a, RST_A);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_a !== exp_a(i)) begin
        n_fail++;
        if (shown < 5) $display("FAIL restart_a t=%0d: got %h expected %h", i, obs_a, exp_a(i));
        shown++;
      end
    end
  endtask

  task automatic test_small_frame();
    int shown = 0;
    rst_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_b !== RST_B) begin
        n_fail++;
        $display("FAIL small_release clk=%0d: got %h expected %h", i, obs_b, RST_B);
      end
    end
    for (t_b = 0; t_b < 800; t_b++) begin
      @(negedge clk);
      n_tests++;
      if (obs_b !== exp_b(t_b)) begin
        n_fail++;
        if (shown < 5) $display("FAIL small_frame t=%0d: got %h expected %h", t_b, obs_b, exp_b(t_b));
        shown++;
      end
    end
    t_b = 799;
  endtask

  task automatic test_midframe_reset();
    int shown = 0;
    // Stop mid-frame at line 7, pixel 13 (back porch).
    while ((t_b % 384) != 250) begin
      @(negedge clk);
      t_b++;
      n_tests++;
      if (obs_b !== exp_b(t_b)) begin
        n_fail++;
        if (shown < 5) $display("FAIL pre_reset_b t=%0d: got %h expected %h", t_b, obs_b, exp_b(t_b));
        shown++;
      end
    end
    rst_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_b !== RST_B) begin
        n_fail++;
        $display("FAIL midframe_reset clk=%0d: got %h expected %h", i, obs_b, RST_B);
      end
    end
    rst_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_b !== RST_B) begin
        n_fail++;
        $display("FAIL midframe_release clk=%0d: got %h expected %h", i, obs_b, RST_B);
      end
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_b !== exp_b(i)) begin
        n_fail++;
        if (shown < 5) $display("FAIL restart_b t=%0d: got %h expected %h", i, obs_b, exp_b(i));
        shown++;
      end
    end
  endtask

  task automatic test_pipe3();
    int shown = 0;
    rst_c = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_c !== RST_C) begin
        n_fail++;
        $display("FAIL pipe3_latency clk=%0d: got %h expected %h", i, obs_c, RST_C);
      end
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs_c !== exp_c(i)) begin
        n_fail++;
        if (shown < 5) $display("FAIL pipe3 t=%0d: got %h expected %h", i, obs_c, exp_c(i));
        shown++;
      end
    end
  endtask

  initial begin
    rst_a = 1'b0;
    en_a  = 1'b1;
    rst_b = 1'b0;
    en_b  = 1'b1;
    rst_c = 1'b0;
    en_c  = 1'b1;
    test_reset();
    test_line_timing();
    test_freeze();
    test_midline_reset_a();
    test_small_frame();
    test_midframe_reset();
    test_pipe3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
